// File: rtl/dht11_axil_slave_if.sv
// AXI4-Lite channel bundle between the bus master and the DHT11 register file.
// The master modport drives requests; the slave modport drives ready/response.
interface dht11_axil_slave_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/dht11_axil_slave.sv
// DHT11 AXI4-Lite register file, 4 x 32-bit; DHT11_AXIL_RO_DATA_EN makes 0xC a read-only sensor word.
// Latency: write commits 1 edge after the later of AW/W, read data 1 edge after AR.
// Backpressure: B and R are held until BREADY/RREADY; no new AW/W while B is pending.
module dht11_axil_slave #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    dht11_axil_slave_if.slave s_axi,
    output logic [DATA_W-1:0] reg0_o,
    output logic [DATA_W-1:0] reg1_o,
    output logic [DATA_W-1:0] reg2_o,
    output logic [DATA_W-1:0] reg3_o,
    input  logic [DATA_W-1:0] sensor_data_i
);
    localparam int NB = DATA_W / 8;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic              live;
    logic              aw_pend;
    logic              w_pend;
    logic [1:0]        aw_idx_q;
    logic [DATA_W-1:0] w_data_q;
    logic [NB-1:0]     w_strb_q;
    logic              bvalid_q;
    logic [0:0]        r_state;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] regs [4];

    logic              aw_hs, w_hs, ar_hs, commit, wr_en;
    logic [1:0]        wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [NB-1:0]     wr_strb;
    logic [DATA_W-1:0] rd_word;
    logic              unused_bits;

    // live keeps every ready low while reset is held and for the first edge after release
    assign s_axi.awready = live && !aw_pend && !bvalid_q;
    assign s_axi.wready  = live && !w_pend && !bvalid_q;
    assign s_axi.arready = live && (r_state == R_IDLE);
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = 2'b00;

    assign aw_hs  = s_axi.awvalid && s_axi.awready;
    assign w_hs   = s_axi.wvalid && s_axi.wready;
    assign ar_hs  = s_axi.arvalid && s_axi.arready;
    assign commit = (aw_pend || aw_hs) && (w_pend || w_hs) && !bvalid_q;

    assign wr_idx  = aw_pend ? aw_idx_q : s_axi.awaddr[3:2];
    assign wr_data = w_pend ? w_data_q : s_axi.wdata;
    assign wr_strb = w_pend ? w_strb_q : s_axi.wstrb;

`ifdef DHT11_AXIL_RO_DATA_EN
    assign wr_en       = commit && (wr_idx != 2'd3);
    assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};
`else
    assign wr_en       = commit;
    assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0],
                           sensor_data_i};
`endif

    always_comb begin
        rd_word = regs[s_axi.araddr[3:2]];
`ifdef DHT11_AXIL_RO_DATA_EN
        if (s_axi.araddr[3:2] == 2'd3) begin
            rd_word = sensor_data_i;
        end
`endif
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            live     <= 1'b0;
            aw_pend  <= 1'b0;
            w_pend   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bvalid_q <= 1'b0;
        end else begin
            live <= 1'b1;
            if (commit) begin
                aw_pend  <= 1'b0;
                w_pend   <= 1'b0;
                bvalid_q <= 1'b1;
            end else begin
                if (aw_hs) begin
                    aw_pend  <= 1'b1;
                    aw_idx_q <= s_axi.awaddr[3:2];
                end
                if (w_hs) begin
                    w_pend   <= 1'b1;
                    w_data_q <= s_axi.wdata;
                    w_strb_q <= s_axi.wstrb;
                end
                if (bvalid_q && s_axi.bready) begin
                    bvalid_q <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_strb[b]) begin
                    regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read capture samples regs before any same-edge write lands, so reads see the old value
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state  <= R_IDLE;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rdata_q  <= rd_word;
                        rvalid_q <= 1'b1;
                        r_state  <= R_DATA;
                    end
                end
                default: begin
                    if (s_axi.rready) begin
                        rvalid_q <= 1'b0;
                        r_state  <= R_IDLE;
                    end
                end
            endcase
        end
    end

    assign reg0_o = regs[0];
    assign reg1_o = regs[1];
    assign reg2_o = regs[2];
    assign reg3_o = regs[3];
endmodule

// File: tb/tb_dht11_axil_slave.sv
// Bench for dht11_axil_slave: directed bus scenarios plus random traffic scored against a register model.
module tb_dht11_axil_slave;
`ifdef DHT11_AXIL_RO_DATA_EN
    localparam bit RO = 1'b1;
`else
    localparam bit RO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] reg0, reg1, reg2, reg3, sensor;

    always #5 clk = ~clk;

    dht11_axil_slave_if #(.ADDR_W(4), .DATA_W(32)) axi ();

    dht11_axil_slave #(.DATA_W(32), .ADDR_W(4)) dut (
        .ACLK          (clk),
        .ARESETN       (rst_n),
        .s_axi         (axi),
        .reg0_o        (reg0),
        .reg1_o        (reg1),
        .reg2_o        (reg2),
        .reg3_o        (reg3),
        .sensor_data_i (sensor)
    );

    typedef struct {
        logic [1:0]  idx;
        logic [31:0] val;
    } wexp_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [4];
    wexp_t       b_q[$];
    logic [31:0] r_q[$];
    int          b_issued = 0, b_done = 0, r_issued = 0, r_done = 0;
    int          b_mode = 0, r_mode = 0;   // 0 always ready, 1 random, 2 held low

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] reg_out(input logic [1:0] i);
        case (i)
            2'd0:    return reg0;
            2'd1:    return reg1;
            2'd2:    return reg2;
            default: return reg3;
        endcase
    endfunction

    function automatic logic [31:0] read_exp(input logic [1:0] i);
        if (RO && i == 2'd3) return sensor;
        return model[i];
    endfunction

    // Response-side ready generator, updated just after each rising edge
    initial begin
        axi.bready = 1'b0;
        axi.rready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            axi.bready = (b_mode == 0) ? 1'b1 : (b_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
            axi.rready = (r_mode == 0) ? 1'b1 : (r_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
        end
    end

    // Monitor: a handshake seen at the falling edge completes on the next rising edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && axi.bvalid && axi.bready) begin
                b_done++;
                if (b_q.size() == 0) begin
                    chk("unexpected_b", 32'd1, 32'd0);
                end else begin
                    wexp_t e;
                    e = b_q.pop_front();
                    chk("bresp", {30'd0, axi.bresp}, 32'd0);
                    chk("b_reg_out", reg_out(e.idx), e.val);
                end
            end
            if (rst_n && axi.rvalid && axi.rready) begin
                r_done++;
                if (r_q.size() == 0) begin
                    chk("unexpected_r", 32'd1, 32'd0);
                end else begin
                    logic [31:0] e;
                    e = r_q.pop_front();
                    chk("rresp", {30'd0, axi.rresp}, 32'd0);
                    chk("rdata", axi.rdata, e);
                end
            end
        end
    end

    task automatic push_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        wexp_t e;
        int    i;
        i = int'(addr[3:2]);
        if (!(RO && i == 3)) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[i][8*b +: 8] = data[8*b +: 8];
            end
        end
        e.idx = addr[3:2];
        e.val = model[i];
        b_q.push_back(e);
        b_issued++;
    endtask

    task automatic push_read(input logic [3:0] addr);
        r_q.push_back(read_exp(addr[3:2]));
        r_issued++;
    endtask

    task automatic drive_aw(input logic [3:0] addr, input int delay);
        int n = 0;
        repeat (delay) @(negedge clk);
        axi.awaddr  = addr;
        axi.awprot  = 3'($urandom);
        axi.awvalid = 1'b1;
        while (!axi.awready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("aw_accepted", {31'd0, axi.awready}, 32'd1);
        @(negedge clk);
        axi.awvalid = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input int delay);
        int n = 0;
        repeat (delay) @(negedge clk);
        axi.wdata  = data;
        axi.wstrb  = strb;
        axi.wvalid = 1'b1;
        while (!axi.wready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("w_accepted", {31'd0, axi.wready}, 32'd1);
        @(negedge clk);
        axi.wvalid = 1'b0;
    endtask

    task automatic drive_ar(input logic [3:0] addr);
        int n = 0;
        axi.araddr  = addr;
        axi.arprot  = 3'($urandom);
        axi.arvalid = 1'b1;
        while (!axi.arready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ar_accepted", {31'd0, axi.arready}, 32'd1);
        @(negedge clk);
        axi.arvalid = 1'b0;
    endtask

    task automatic wait_b();
        int n = 0;
        while (b_done != b_issued && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("b_drained", b_done, b_issued);
    endtask

    task automatic wait_r();
        int n = 0;
        while (r_done != r_issued && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("r_drained", r_done, r_issued);
    endtask

    // lead > 0: W leads AW by that many cycles; lead < 0: AW leads W
    task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int lead);
        push_write(addr, data, strb);
        fork
            drive_aw(addr, (lead > 0) ? lead : 0);
            drive_w(data, strb, (lead < 0) ? -lead : 0);
        join
        wait_b();
    endtask

    task automatic do_read(input logic [3:0] addr);
        push_read(addr);
        drive_ar(addr);
        wait_r();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_awready"}, {31'd0, axi.awready}, 32'd0);
        chk({tag, "_wready"},  {31'd0, axi.wready},  32'd0);
        chk({tag, "_bvalid"},  {31'd0, axi.bvalid},  32'd0);
        chk({tag, "_arready"}, {31'd0, axi.arready}, 32'd0);
        chk({tag, "_rvalid"},  {31'd0, axi.rvalid},  32'd0);
        chk({tag, "_rdata"},   axi.rdata,            32'd0);
        chk({tag, "_bresp"},   {30'd0, axi.bresp},   32'd0);
        chk({tag, "_rresp"},   {30'd0, axi.rresp},   32'd0);
        chk({tag, "_reg0"}, reg0, 32'd0);
        chk({tag, "_reg1"}, reg1, 32'd0);
        chk({tag, "_reg2"}, reg2, 32'd0);
        chk({tag, "_reg3"}, reg3, 32'd0);
    endtask

    initial begin
        logic [31:0] old_val;
        logic [3:0]  addr;
        int          lead;

        for (int i = 0; i < 4; i++) model[i] = 32'd0;
        rst_n = 1'b0;
        sensor = 32'd0;
        axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
        axi.wdata = '0;  axi.wstrb = '0;  axi.wvalid = 1'b0;
        axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Sequential write then read-back of all four registers
        for (int i = 0; i < 4; i++) do_write(4'(i * 4), 32'(i + 1), 4'hF, 0);
        for (int i = 0; i < 4; i++) do_read(4'(i * 4));

        // W three cycles ahead of AW: single commit one edge after AW
        push_write(4'h4, 32'hA5A5_0000, 4'hF);
        drive_w(32'hA5A5_0000, 4'hF, 0);
        repeat (2) @(negedge clk);
        axi.awaddr  = 4'h4;
        axi.awvalid = 1'b1;
        chk("aw_ready_after_w", {31'd0, axi.awready}, 32'd1);
        @(negedge clk);
        axi.awvalid = 1'b0;
        chk("b_one_after_aw", {31'd0, axi.bvalid}, 32'd1);
        chk("reg1_w_first", reg1, 32'hA5A5_0000);
        wait_b();

        // Byte strobes
        do_write(4'h8, 32'hFFFF_FFFF, 4'hF, 0);
        do_write(4'h8, 32'h1234_5678, 4'b0101, -2);
        chk("reg2_strobed", reg2, 32'hFF34_FF78);
        do_read(4'h8);
        do_write(4'h0, 32'hDEAD_BEEF, 4'h0, 1);

        // B held off: no further AW/W acceptance while the response waits
        b_mode = 2;
        @(negedge clk);
        push_write(4'h0, 32'h0BAD_F00D, 4'hF);
        fork
            drive_aw(4'h0, 0);
            drive_w(32'h0BAD_F00D, 4'hF, 0);
        join
        for (int k = 0; k < 5; k++) begin
            chk("b_held", {31'd0, axi.bvalid}, 32'd1);
            chk("awready_blocked", {31'd0, axi.awready}, 32'd0);
            chk("wready_blocked", {31'd0, axi.wready}, 32'd0);
            @(negedge clk);
        end
        b_mode = 0;
        wait_b();

        // R held off, with a same-edge write to the register being read
        r_mode = 2;
        @(negedge clk);
        old_val = read_exp(2'd2);
        push_read(4'h8);
        fork
            drive_ar(4'h8);
            do_write(4'h8, 32'h7777_1111, 4'hF, 0);
        join
        for (int k = 0; k < 5; k++) begin
            chk("r_held", {31'd0, axi.rvalid}, 32'd1);
            chk("rdata_stable", axi.rdata, old_val);
            chk("arready_blocked", {31'd0, axi.arready}, 32'd0);
            @(negedge clk);
        end
        r_mode = 0;
        wait_r();

        // Offset 0xC with a live sensor word
        sensor = 32'h2A00_1900;
        do_write(4'hC, 32'h5, 4'hF, 0);
        chk("reg3_after_write", reg3, RO ? 32'd0 : 32'd5);
        do_read(4'hC);

        // Random traffic with random response backpressure
        b_mode = 1;
        r_mode = 1;
        for (int k = 0; k < 80; k++) begin
            sensor = $urandom;
            addr   = 4'($urandom);
            lead   = int'($urandom_range(0, 6)) - 3;
            if ($urandom_range(0, 1) == 1) do_write(addr, $urandom, 4'($urandom), lead);
            else                           do_read(addr);
        end
        b_mode = 0;
        r_mode = 0;
        repeat (3) @(negedge clk);

        // Reset while a W is latched: it must be forgotten
        drive_w(32'h1357_9BDF, 4'hF, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        for (int i = 0; i < 4; i++) model[i] = 32'd0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        drive_aw(4'h0, 0);
        for (int k = 0; k < 3; k++) begin
            chk("no_b_after_reset", {31'd0, axi.bvalid}, 32'd0);
            @(negedge clk);
        end
        push_write(4'h0, 32'h2468_ACE0, 4'hF);
        drive_w(32'h2468_ACE0, 4'hF, 0);
        wait_b();
        do_read(4'h0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
